audio_sync_tx: RTL and testbench
================================

Name: audio_sync_tx

Overview:
- Source-domain transmit end of the audio sample clock-domain crossing.
- Captures a strobed sample, holds it stable on `dout`, and signals it with a toggle request.
- Waits for the toggled acknowledge returned from the destination domain, so the destination capture register sees a static bus.
- One-deep latest-wins pending buffer absorbs samples strobed while a transfer is in flight; the audio producer never stalls.

Parameters:
- AUDIO_DW, 16: sample width in bits.
- OVR_CW, 8: overrun counter width (used only with the optional feature).

Ports:
- clk  in  1  source-domain clock.
- reset_n  in  1  asynchronous active-low reset.
- din  in  AUDIO_DW  sample from the producer.
- din_stb  in  1  one-cycle strobe; `din` is valid this cycle.
- dout  out  AUDIO_DW  registered sample presented to the other domain; static while a transfer is pending.
- req  out  1  toggle request; each edge means a new sample is on `dout`.
- ack_async  in  1  toggle acknowledge from the destination domain; asynchronous to `clk`.
- busy  out  1  high while a transfer is unacknowledged (not IDLE).
- pend_valid  out  1  pending register holds an unsent sample.
- ovr_cnt  out  OVR_CW  overrun count (optional feature only).

Behaviour:
- Reset values: `dout`=0, `req`=0, `busy`=1, `pend_valid`=0, `ovr_cnt`=0, `ack_s` sync flops=0, state=RESYNC.
- Reset is asynchronous assert; deassertion is registered on the next `clk` edge.
- `ack_async` passes through a 2-flop synchronizer (ASYNC_REG) to give `ack_s`. No other logic touches `ack_async`.
- States and transitions:
  - RESYNC: wait until `ack_s`==`req`, then go to IDLE. Covers the destination still showing a stale ack after a mid-transfer reset. Strobes seen here go to pending.
  - IDLE: on `din_stb`, load `dout`<=`din`, toggle `req`, go to WAIT. Latency from strobe cycle N to new `dout`/`req` edge is N+1. If `pend_valid`=1 on entry, launch the pending sample the cycle after entry and clear `pend_valid`.
  - WAIT: `dout` and `req` frozen. When `ack_s`==`req`:
    - if `pend_valid` or `din_stb` this cycle, relaunch next cycle (LAUNCH);
    - otherwise go to IDLE.
  - LAUNCH: `dout`<=pending (or `din` if strobed this cycle, newest wins), toggle `req`, clear `pend_valid`, go to WAIT.
- `busy` = (state != IDLE).
- Simultaneous `din_stb` and pending launch in the same cycle: the strobed `din` is sent; the older pending sample is discarded as an overrun.
- `din_stb` while in WAIT or RESYNC: pending <= `din`, `pend_valid`=1. If `pend_valid` was already 1, the old pending value is overwritten, which is an overrun.
- Minimum round trip: 1 launch + destination latency + 2 sync cycles. The block imposes no extra hold; `dout` never changes between a `req` edge and the matching `ack_s` edge.
- `req` comes straight from a flop, with no combinational path to the output.

Optional Feature:
- Macro: AUDIO_SYNC_TX_OVR_CNT_EN.
- Defined:
  - `ovr_cnt` increments by 1 on every overrun (pending overwrite, or pending discarded by a simultaneous strobe).
  - The counter saturates at all-ones and never wraps.
  - It is cleared only by reset.
- Undefined: the `ovr_cnt` port is still present but tied to 0; no counter logic is synthesized.

Decomposition:
- Shared package `audio_pkg`:
  - AUDIO_DW default;
  - state enum (RESYNC, IDLE, WAIT, LAUNCH);
  - SYNC_STAGES=2 constant, also used by the receive side.
- Sub-module `audio_bit_sync`: a generic 2-flop single-bit synchronizer with ASYNC_REG attributes, used for `ack_async`.
- Remainder (FSM, pending register, counter) is flat in `audio_sync_tx`.

Test Plan:
1. Single transfer:
   - Setup: reset, ack loopback of `req` through a 3-cycle delay; `din`=16'h1234 strobed at cycle 10.
   - Expect: `dout`=16'h1234 and `req` 0->1 at cycle 11; `busy` holds until `ack_s` matches; `dout` stable throughout; then IDLE.
2. Back-to-back:
   - Stimulus: strobe 16'hAAAA, then 16'h5555 two cycles later (during WAIT).
   - Expect: `pend_valid`=1; after ack, 16'h5555 launched with a second `req` toggle; `ovr_cnt`=0.
3. Overrun:
   - Stimulus: strobe 16'h0001, 16'h0002, 16'h0003 while WAIT.
   - Expect: only 16'h0001 then 16'h0003 sent; `ovr_cnt`=1 (feature on) or 0 (feature off).
4. Saturation:
   - Setup: OVR_CW=2, with 5 overruns.
   - Expect: `ovr_cnt` stops at 3.
5. Mid-transfer reset:
   - Stimulus: assert `reset_n` low while WAIT with `ack_async` held at 1.
   - Expect: outputs go to reset values at once; the block stays in RESYNC with `busy`=1 until `ack_async` returns to 0 (+2 cycles), then accepts 16'hBEEF normally.
6. Simultaneous strobe and ack-match:
   - Setup: pending 16'h1111, strobe 16'h2222 in the ack-match cycle.
   - Expect: 16'h2222 launched; 16'h1111 dropped; `ovr_cnt`+1.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and types for both ends of the audio sample clock-domain crossing.
package audio_pkg;

  localparam int AUDIO_DW_DEFAULT = 16;

  // Depth of every single-bit synchronizer on either side of the crossing.
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LAUNCH = 2'd3
  } tx_state_e;

endpackage

// File: rtl/audio_bit_sync.sv
// Generic multi-flop single-bit synchronizer for a level or toggle crossing into clk.
module audio_bit_sync
  import audio_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/audio_sync_tx.sv
// Source-side toggle req/ack sender for audio samples with a one-deep latest-wins buffer.
// Define AUDIO_SYNC_TX_OVR_CNT_EN to build the saturating overrun counter on ovr_cnt.
module audio_sync_tx
  import audio_pkg::*;
#(
  parameter int AUDIO_DW = AUDIO_DW_DEFAULT,
  parameter int OVR_CW   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [AUDIO_DW-1:0] din,
  input  logic                din_stb,
  output logic [AUDIO_DW-1:0] dout,
  output logic                req,
  input  logic                ack_async,
  output logic                busy,
  output logic                pend_valid,
  output logic [OVR_CW-1:0]   ovr_cnt
);

  localparam logic [1:0] S_RESYNC = ST_RESYNC;
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_LAUNCH = ST_LAUNCH;

  localparam int                  SETTLE_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

  logic [1:0]          r_state;
  logic [AUDIO_DW-1:0] r_dout;
  logic                r_req;
  logic [AUDIO_DW-1:0] r_pend;
  logic                r_pend_valid;
  logic [SETTLE_W-1:0] r_settle;

  logic [1:0]          w_state_next;
  logic [AUDIO_DW-1:0] w_dout_next;
  logic                w_req_next;
  logic [AUDIO_DW-1:0] w_pend_next;
  logic                w_pend_valid_next;
  logic                w_ack_s;
  logic                w_ack_match;
  logic                w_settled;

  audio_bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (ack_async),
    .o_q     (w_ack_s)
  );

  assign w_ack_match = (w_ack_s == r_req);
  // The synchronizer's reset value says nothing about the real ack level, so
  // RESYNC only trusts ack_s once a fresh sample has propagated through it.
  assign w_settled   = (r_settle == SETTLE_DONE);

  always_comb begin
    w_state_next      = r_state;
    w_dout_next       = r_dout;
    w_req_next        = r_req;
    w_pend_next       = r_pend;
    w_pend_valid_next = r_pend_valid;
    case (r_state)
      S_RESYNC: begin
        if (din_stb) begin
          w_pend_next       = din;
          w_pend_valid_next = 1'b1;
        end
        if (w_settled && w_ack_match) begin
          w_state_next = S_IDLE;
        end
      end
      S_IDLE, S_LAUNCH: begin
        if (din_stb || r_pend_valid) begin
          w_dout_next       = din_stb ? din : r_pend;
          w_req_next        = ~r_req;
          w_pend_valid_next = 1'b0;
          w_state_next      = S_WAIT;
        end else begin
          w_state_next      = S_IDLE;
        end
      end
      S_WAIT: begin
        if (din_stb) begin
          w_pend_next       = din;
          w_pend_valid_next = 1'b1;
        end
        if (w_ack_match) begin
          w_state_next = (din_stb || r_pend_valid) ? S_LAUNCH : S_IDLE;
        end
      end
      default: begin
        w_state_next = S_RESYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_RESYNC;
      r_dout       <= '0;
      r_req        <= 1'b0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_settle     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_dout       <= w_dout_next;
      r_req        <= w_req_next;
      r_pend       <= w_pend_next;
      r_pend_valid <= w_pend_valid_next;
      if (r_state == S_RESYNC && !w_settled) begin
        r_settle <= r_settle + 1'b1;
      end
    end
  end

  assign dout       = r_dout;
  assign req        = r_req;
  assign busy       = (r_state != S_IDLE);
  assign pend_valid = r_pend_valid;

`ifdef AUDIO_SYNC_TX_OVR_CNT_EN
  logic              w_overrun;
  logic [OVR_CW-1:0] r_ovr_cnt;

  // In every state a strobe landing on a valid pending sample retires that
  // sample unsent: either overwritten or displaced by the newer launch.
  assign w_overrun = din_stb && r_pend_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr_cnt <= '0;
    end else if (w_overrun && (r_ovr_cnt != '1)) begin
      r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end
  end

  assign ovr_cnt = r_ovr_cnt;
`else
  assign ovr_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_sync_tx.sv
// Self-checking bench for audio_sync_tx: directed scenarios plus randomized strobes against a latest-wins model.
module tb_audio_sync_tx;

  localparam int DW  = 16;
  localparam int OCW = 2;
  localparam int OVR_MAX = (1 << OCW) - 1;
`ifdef AUDIO_SYNC_TX_OVR_CNT_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [DW-1:0]  din = '0;
  logic           din_stb = 1'b0;
  logic [DW-1:0]  dout;
  logic           req;
  logic           ack_async = 1'b0;
  logic           busy;
  logic           pend_valid;
  logic [OCW-1:0] ovr_cnt;

  always #5 clk = ~clk;

  audio_sync_tx #(
    .AUDIO_DW (DW),
    .OVR_CW   (OCW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_stb    (din_stb),
    .dout       (dout),
    .req        (req),
    .ack_async  (ack_async),
    .busy       (busy),
    .pend_valid (pend_valid),
    .ovr_cnt    (ovr_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Destination model: ack follows req after ack_dly cycles, or is forced to a level.
  logic [15:0] req_hist = '0;
  int          ack_dly = 3;
  bit          ack_hold = 1'b0;
  logic        ack_hold_val = 1'b0;

  always @(posedge clk) begin
    #2;
    req_hist  = {req_hist[14:0], req};
    ack_async = ack_hold ? ack_hold_val : req_hist[ack_dly];
  end

  // Reference: every req edge must carry the newest strobed sample, and must
  // follow at least one strobe since the previous edge. Unsent strobes are overruns.
  logic [DW-1:0] last_stb_val;
  bit            fresh;
  int            n_stb;
  int            n_sent;
  logic [DW-1:0] sent_q[$];
  logic          prev_req = 1'b0;
  logic [DW-1:0] prev_dout = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      last_stb_val = '0;
      fresh        = 1'b0;
      n_stb        = 0;
      n_sent       = 0;
      sent_q.delete();
    end else begin
      if (req !== prev_req) begin
        chk("fresh_sample", 32'(fresh), 32'd1);
        chk("sent_value", 32'(dout), 32'(last_stb_val));
        n_sent++;
        fresh = 1'b0;
        sent_q.push_back(dout);
        $display("send #%0d: dout=0x%04h", n_sent, dout);
      end else begin
        chk("dout_hold", 32'(dout), 32'(prev_dout));
      end
      if (din_stb) begin
        last_stb_val = din;
        fresh        = 1'b1;
        n_stb++;
      end
    end
    prev_req  = req;
    prev_dout = dout;
  end

  function automatic logic [31:0] exp_ovr();
    int d;
    d = n_stb - n_sent;
    if (d > OVR_MAX) d = OVR_MAX;
    return OVR_ON ? 32'(d) : 32'd0;
  endfunction

  task automatic step(input bit stb, input logic [DW-1:0] val);
    @(posedge clk);
    #1;
    din_stb = stb;
    din     = val;
  endtask

  task automatic do_reset();
    din_stb = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    int k;
    k = 0;
    step(1'b0, '0);
    while ((busy !== 1'b0 || pend_valid !== 1'b0) && k < 200) begin
      step(1'b0, '0);
      k++;
    end
    chk({tag, "_idle"}, 32'({busy, pend_valid}), 32'd0);
    chk({tag, "_last"}, 32'(dout), 32'(last_stb_val));
    chk({tag, "_ovr"}, 32'(ovr_cnt), exp_ovr());
  endtask

  initial begin
    // Reset values while reset is held
    #2;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_pend", 32'(pend_valid), 32'd0);
    chk("rst_ovr", 32'(ovr_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1: single transfer, strobe at cycle 10, visible at cycle 11
    ack_dly = 3;
    repeat (9) step(1'b0, '0);
    step(1'b1, 16'h1234);
    @(negedge clk);
    chk("t1_req_pre", 32'(req), 32'd0);
    step(1'b0, '0);
    @(negedge clk);
    chk("t1_dout", 32'(dout), 32'h1234);
    chk("t1_req", 32'(req), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    check_idle("t1");
    chk("t1_nsent", 32'(sent_q.size()), 32'd1);

    // 2: back-to-back, second strobe lands in WAIT
    do_reset();
    repeat (6) step(1'b0, '0);
    step(1'b1, 16'hAAAA);
    step(1'b0, '0);
    step(1'b1, 16'h5555);
    step(1'b0, '0);
    chk("t2_pend", 32'(pend_valid), 32'd1);
    check_idle("t2");
    chk("t2_nsent", 32'(sent_q.size()), 32'd2);
    chk("t2_s0", 32'(sent_q[0]), 32'hAAAA);
    chk("t2_s1", 32'(sent_q[1]), 32'h5555);
    chk("t2_ovr0", 32'(ovr_cnt), 32'd0);

    // 3: overrun, middle sample dropped
    do_reset();
    repeat (6) step(1'b0, '0);
    step(1'b1, 16'h0001);
    step(1'b1, 16'h0002);
    step(1'b1, 16'h0003);
    check_idle("t3");
    chk("t3_nsent", 32'(sent_q.size()), 32'd2);
    chk("t3_s0", 32'(sent_q[0]), 32'h0001);
    chk("t3_s1", 32'(sent_q[1]), 32'h0003);
    chk("t3_ovr", 32'(ovr_cnt), OVR_ON ? 32'd1 : 32'd0);

    // 4: five overruns saturate a 2-bit counter
    do_reset();
    repeat (6) step(1'b0, '0);
    for (int i = 1; i <= 7; i++) step(1'b1, 16'(i));
    check_idle("t4");
    chk("t4_nsent", 32'(sent_q.size()), 32'd2);
    chk("t4_s1", 32'(sent_q[1]), 32'h0007);
    chk("t4_ovr", 32'(ovr_cnt), OVR_ON ? 32'd3 : 32'd0);

    // 6: strobe in the ack-match cycle displaces the pending sample
    ack_hold = 1'b1;
    ack_hold_val = 1'b0;
    do_reset();
    repeat (6) step(1'b0, '0);
    step(1'b1, 16'h0A0A);
    step(1'b0, '0);
    step(1'b1, 16'h1111);
    step(1'b0, '0);
    ack_hold_val = 1'b1;
    step(1'b0, '0);
    step(1'b1, 16'h2222);
    chk("t6_pend", 32'(pend_valid), 32'd1);
    step(1'b0, '0);
    ack_hold = 1'b0;
    check_idle("t6");
    chk("t6_nsent", 32'(sent_q.size()), 32'd2);
    chk("t6_s1", 32'(sent_q[1]), 32'h2222);
    chk("t6_ovr", 32'(ovr_cnt), OVR_ON ? 32'd1 : 32'd0);

    // 5: reset mid-transfer with the destination still showing ack=1
    ack_hold = 1'b1;
    ack_hold_val = 1'b0;
    do_reset();
    repeat (6) step(1'b0, '0);
    step(1'b1, 16'h7777);
    step(1'b0, '0);
    step(1'b1, 16'h4242);
    ack_hold_val = 1'b1;
    step(1'b0, '0);
    chk("t5_pend_pre", 32'(pend_valid), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_dout", 32'(dout), 32'd0);
    chk("t5_rst_req", 32'(req), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd1);
    chk("t5_rst_pend", 32'(pend_valid), 32'd0);
    chk("t5_rst_ovr", 32'(ovr_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0);
      chk("t5_resync_busy", 32'(busy), 32'd1);
    end
    ack_hold_val = 1'b0;
    begin
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 8) begin
        step(1'b0, '0);
        k++;
      end
      chk("t5_resync_exit", 32'(busy), 32'd0);
    end
    ack_hold = 1'b0;
    step(1'b1, 16'hBEEF);
    @(negedge clk);
    chk("t5_req_pre", 32'(req), 32'd0);
    step(1'b0, '0);
    @(negedge clk);
    chk("t5_dout", 32'(dout), 32'hBEEF);
    chk("t5_req", 32'(req), 32'd1);
    check_idle("t5");

    // Randomized strobes under varying destination latency
    do_reset();
    repeat (6) step(1'b0, '0);
    for (int r = 0; r < 6; r++) begin
      ack_dly = $urandom_range(1, 6);
      for (int c = 0; c < 150; c++) begin
        step($urandom_range(0, 99) < 30, 16'($urandom));
      end
      check_idle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
